// File: rtl/exe_stage.sv
// Execute stage: operand forwarding muxes, ALU with NZCV generation, branch target
// adder, architectural status register and the EXE/MEM pipeline register.
module exe_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic [3:0]       EXE_CMD,
    input  logic             WB_EN,
    input  logic             MEM_R_EN,
    input  logic             MEM_W_EN,
    input  logic             S,
    input  logic             B,
    input  logic             I,
    input  logic [WIDTH-1:0] PC,
    input  logic [WIDTH-1:0] Val_Rn,
    input  logic [WIDTH-1:0] Val_Rm,
    input  logic [WIDTH-1:0] Imm32,
    input  logic [23:0]      Signed_imm_24,
    input  logic [3:0]       Dest,
    input  logic [1:0]       Sel_src1,
    input  logic [1:0]       Sel_src2,
    input  logic [WIDTH-1:0] MEM_fwd_val,
    input  logic [WIDTH-1:0] WB_fwd_val,
    output logic             Br_taken,
    output logic [WIDTH-1:0] Br_addr,
    output logic [3:0]       SR,
    output logic             EM_WB_EN,
    output logic             EM_MEM_R_EN,
    output logic             EM_MEM_W_EN,
    output logic [WIDTH-1:0] EM_ALU_Res,
    output logic [WIDTH-1:0] EM_Val_Rm,
    output logic [3:0]       EM_Dest
);

    localparam int unsigned OFF_W = 24;
    localparam int unsigned EXT_W = WIDTH - OFF_W - 2;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] rm_fwd;
    logic [WIDTH-1:0] op2;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             flag_c;
    logic             flag_v;
    logic             cmd_valid;
    logic             cin;

    assign cin = SR[1];

    // Forwarding selects; code 3 falls back to the ID/EXE value
    always_comb begin
        unique case (Sel_src1)
            2'd1:    op1 = MEM_fwd_val;
            2'd2:    op1 = WB_fwd_val;
            default: op1 = Val_Rn;
        endcase
        unique case (Sel_src2)
            2'd1:    rm_fwd = MEM_fwd_val;
            2'd2:    rm_fwd = WB_fwd_val;
            default: rm_fwd = Val_Rm;
        endcase
    end

    assign op2 = I ? Imm32 : rm_fwd;

    // Subtracts are op1 + ~op2 + carry so bit WIDTH of the sum is NOT borrow
    always_comb begin
        sum       = '0;
        alu_res   = '0;
        flag_c    = SR[1];
        flag_v    = SR[0];
        cmd_valid = 1'b1;
        case (EXE_CMD)
            CMD_MOV: alu_res = op2;
            CMD_MVN: alu_res = ~op2;
            CMD_AND: alu_res = op1 & op2;
            CMD_ORR: alu_res = op1 | op2;
            CMD_EOR: alu_res = op1 ^ op2;
            CMD_ADD, CMD_ADC: begin
                sum = {1'b0, op1} + {1'b0, op2}
                    + (WIDTH+1)'((EXE_CMD == CMD_ADC) ? cin : 1'b0);
                alu_res = sum[WIDTH-1:0];
                flag_c  = sum[WIDTH];
                flag_v  = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
            end
            CMD_SUB, CMD_SBC: begin
                sum = {1'b0, op1} + {1'b0, ~op2}
                    + (WIDTH+1)'((EXE_CMD == CMD_SBC) ? cin : 1'b1);
                alu_res = sum[WIDTH-1:0];
                flag_c  = sum[WIDTH];
                flag_v  = (op1[WIDTH-1] != op2[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
            end
            default: cmd_valid = 1'b0;
        endcase
    end

    assign Br_taken = B;
    assign Br_addr  = PC + {{EXT_W{Signed_imm_24[OFF_W-1]}}, Signed_imm_24, 2'b00};

    // Status register: only valid ALU commands with S set commit flags
    always_ff @(posedge clk) begin
        if (rst) begin
            SR <= 4'b0000;
        end else if (!freeze && S && cmd_valid) begin
            SR <= {alu_res[WIDTH-1], (alu_res == '0), flag_c, flag_v};
        end
    end

    // EXE/MEM pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            EM_WB_EN    <= 1'b0;
            EM_MEM_R_EN <= 1'b0;
            EM_MEM_W_EN <= 1'b0;
            EM_ALU_Res  <= '0;
            EM_Val_Rm   <= '0;
            EM_Dest     <= '0;
        end else if (!freeze) begin
            EM_WB_EN    <= WB_EN;
            EM_MEM_R_EN <= MEM_R_EN;
            EM_MEM_W_EN <= MEM_W_EN;
            EM_ALU_Res  <= alu_res;
            EM_Val_Rm   <= rm_fwd;
            EM_Dest     <= Dest;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: directed scenarios followed by random traffic,
// checked against an arithmetic reference model of the execute stage.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst, freeze, WB_EN, MEM_R_EN, MEM_W_EN, S, B, I;
    logic [3:0]  EXE_CMD, Dest;
    logic [31:0] PC, Val_Rn, Val_Rm, Imm32, MEM_fwd_val, WB_fwd_val;
    logic [23:0] Signed_imm_24;
    logic [1:0]  Sel_src1, Sel_src2;
    logic        Br_taken, EM_WB_EN, EM_MEM_R_EN, EM_MEM_W_EN;
    logic [31:0] Br_addr, EM_ALU_Res, EM_Val_Rm;
    logic [3:0]  SR, EM_Dest;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        wb, mr, mw;
        logic [31:0] res, rm;
        logic [3:0]  dest, sr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    exp_t m;   // model of committed state

    always #5 clk = ~clk;

    exe_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .EXE_CMD(EXE_CMD),
        .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .S(S), .B(B), .I(I), .PC(PC), .Val_Rn(Val_Rn), .Val_Rm(Val_Rm),
        .Imm32(Imm32), .Signed_imm_24(Signed_imm_24), .Dest(Dest),
        .Sel_src1(Sel_src1), .Sel_src2(Sel_src2),
        .MEM_fwd_val(MEM_fwd_val), .WB_fwd_val(WB_fwd_val),
        .Br_taken(Br_taken), .Br_addr(Br_addr), .SR(SR),
        .EM_WB_EN(EM_WB_EN), .EM_MEM_R_EN(EM_MEM_R_EN), .EM_MEM_W_EN(EM_MEM_W_EN),
        .EM_ALU_Res(EM_ALU_Res), .EM_Val_Rm(EM_Val_Rm), .EM_Dest(EM_Dest)
    );

    function automatic void check(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h (t=%0t)", nm, act, req, $time);
        end
    endfunction

    function automatic logic [31:0] fwd(logic [1:0] sel, logic [31:0] own);
        if (sel == 2'd1) return MEM_fwd_val;
        if (sel == 2'd2) return WB_fwd_val;
        return own;
    endfunction

    // Reference ALU: unsigned/signed 64-bit arithmetic decides carry and overflow
    task automatic model_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] sr, output logic [31:0] r,
                             output logic [3:0] nzcv, output logic ok);
        longint ua, ub, sa, sbv, full;
        logic c, v;
        ua = longint'(a); ub = longint'(b);
        sa = longint'($signed(a)); sbv = longint'($signed(b));
        c = sr[1]; v = sr[0]; ok = 1'b1; r = 32'h0;
        case (cmd)
            4'b0001: r = b;
            4'b1001: r = ~b;
            4'b0110: r = a & b;
            4'b0111: r = a | b;
            4'b1000: r = a ^ b;
            4'b0010, 4'b0011: begin
                full = ua + ub + ((cmd == 4'b0011) ? longint'(sr[1]) : 0);
                r = full[31:0];
                c = full > 64'sd4294967295;
                full = sa + sbv + ((cmd == 4'b0011) ? longint'(sr[1]) : 0);
                v = (full > 64'sd2147483647) || (full < -64'sd2147483648);
            end
            4'b0100, 4'b0101: begin
                full = (cmd == 4'b0101) ? longint'(!sr[1]) : 0;
                c = ua >= ub + full;
                r = 32'(ua - ub - full);
                full = sa - sbv - full;
                v = (full > 64'sd2147483647) || (full < -64'sd2147483648);
            end
            default: ok = 1'b0;
        endcase
        nzcv = {r[31], r == 32'h0, c, v};
    endtask

    // Apply the current inputs for one cycle; predict and enqueue the registered result
    task automatic tick();
        logic [31:0] op1, rmf, op2, r, br;
        logic [3:0]  nzcv;
        logic        ok;
        #1;
        br = 32'(longint'(PC) + longint'($signed(Signed_imm_24)) * 4);
        check("br_taken", {31'b0, Br_taken}, {31'b0, B});
        check("br_addr", Br_addr, br);
        op1 = fwd(Sel_src1, Val_Rn);
        rmf = fwd(Sel_src2, Val_Rm);
        op2 = I ? Imm32 : rmf;
        model_alu(EXE_CMD, op1, op2, m.sr, r, nzcv, ok);
        if (rst) begin
            m = '0;
        end else if (!freeze) begin
            m.wb = WB_EN; m.mr = MEM_R_EN; m.mw = MEM_W_EN;
            m.res = r; m.rm = rmf; m.dest = Dest;
            if (S && ok) m.sr = nzcv;
        end
        sb.push_back(m);
        @(negedge clk);
    endtask

    task automatic alu_in(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] imm,
                          input logic s);
        EXE_CMD = cmd; Val_Rn = rn; Imm32 = imm; I = 1'b1; S = s;
        Sel_src1 = 2'd0; Sel_src2 = 2'd0;
    endtask

    function automatic logic [31:0] rval();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: one registered result per clock edge once stimulus has started
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("em_wb_en", {31'b0, EM_WB_EN}, {31'b0, mon_e.wb});
                check("em_mem_r_en", {31'b0, EM_MEM_R_EN}, {31'b0, mon_e.mr});
                check("em_mem_w_en", {31'b0, EM_MEM_W_EN}, {31'b0, mon_e.mw});
                check("em_alu_res", EM_ALU_Res, mon_e.res);
                check("em_val_rm", EM_Val_Rm, mon_e.rm);
                check("em_dest", {28'b0, EM_Dest}, {28'b0, mon_e.dest});
                check("sr", {28'b0, SR}, {28'b0, mon_e.sr});
            end
        end
    end

    initial begin
        m = '0;
        rst = 1'b1; freeze = 1'b0; WB_EN = 1'b0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
        S = 1'b0; B = 1'b0; I = 1'b0; EXE_CMD = 4'h0; Dest = 4'h0;
        PC = 32'h0; Val_Rn = 32'h0; Val_Rm = 32'h0; Imm32 = 32'h0;
        MEM_fwd_val = 32'h0; WB_fwd_val = 32'h0; Signed_imm_24 = 24'h0;
        Sel_src1 = 2'd0; Sel_src2 = 2'd0;
        tick(); tick();
        rst = 1'b0;

        // Forwarding sweep: expected results 6, 8, 10, 6
        alu_in(4'b0010, 32'd5, 32'd1, 1'b0);
        MEM_fwd_val = 32'd7; WB_fwd_val = 32'd9; Val_Rm = 32'd11; WB_EN = 1'b1; Dest = 4'd3;
        for (int s = 0; s < 4; s++) begin
            Sel_src1 = 2'(s); Sel_src2 = 2'(3 - s);
            tick();
        end

        // ADD overflow then CMP / SBC carry chain
        alu_in(4'b0010, 32'h7FFF_FFFF, 32'd1, 1'b1); tick();
        alu_in(4'b0100, 32'd3, 32'd3, 1'b1); tick();
        alu_in(4'b0101, 32'd10, 32'd4, 1'b1); tick();
        alu_in(4'b0011, 32'hFFFF_FFFF, 32'd0, 1'b1); tick();

        // Freeze for three cycles while the inputs change to a flag-setting SUB
        alu_in(4'b0010, 32'd1, 32'd2, 1'b0); tick();
        freeze = 1'b1;
        for (int k = 0; k < 3; k++) begin
            alu_in(4'b0100, 32'd20 + 32'(k), 32'd30, 1'b1); MEM_W_EN = 1'b1; Dest = 4'(k);
            tick();
        end
        freeze = 1'b0; tick();

        // Reset asserted with freeze after nonzero state
        alu_in(4'b1001, 32'd0, 32'd0, 1'b1); tick();
        rst = 1'b1; freeze = 1'b1; tick();
        rst = 1'b0; freeze = 1'b0;

        // Branch target with a negative offset
        PC = 32'h100; Signed_imm_24 = 24'hFFFFFE; B = 1'b1; tick();
        B = 1'b0;

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            freeze = ($urandom_range(0, 4) == 0);
            EXE_CMD = 4'($urandom); S = 1'($urandom); B = 1'($urandom); I = 1'($urandom);
            WB_EN = 1'($urandom); MEM_R_EN = 1'($urandom); MEM_W_EN = 1'($urandom);
            Dest = 4'($urandom); Sel_src1 = 2'($urandom); Sel_src2 = 2'($urandom);
            PC = $urandom; Signed_imm_24 = 24'($urandom);
            Val_Rn = rval(); Val_Rm = rval(); Imm32 = rval();
            MEM_fwd_val = rval(); WB_fwd_val = rval();
            tick();
        end

        @(posedge clk); #2;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the 5-stage ARM pipeline. Sits between the ID/EXE and EXE/MEM pipeline boundaries. Selects each ALU operand from the ID/EXE value, the MEM-stage result or the WB value, using the select codes produced by the forwarding unit. Computes the ALU result, the NZCV flags and the branch target, and holds the architectural status register and the EXE/MEM pipeline register.

## Interface
Parameters:
- WIDTH, 32, datapath width (must be 32)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- freeze  in  1  hold EXE/MEM register and status register (memory stall)
- EXE_CMD  in  4  ALU command
- WB_EN, MEM_R_EN, MEM_W_EN  in  1 each  control from ID/EXE
- S  in  1  update status register
- B  in  1  branch instruction
- I  in  1  operand 2 is immediate
- PC  in  32  PC+4 of this instruction
- Val_Rn, Val_Rm  in  32  register-file operands
- Imm32  in  32  rotated immediate (shifter already applied upstream)
- Signed_imm_24  in  24  branch offset
- Dest  in  4  destination register
- Sel_src1, Sel_src2  in  2  forwarding selects: 0 = ID/EXE, 1 = MEM result, 2 = WB value, 3 treated as 0
- MEM_fwd_val  in  32  ALU result currently in MEM
- WB_fwd_val  in  32  value currently written back
- Br_taken  out  1  combinational, equals B
- Br_addr  out  32  combinational branch target
- SR  out  4  status register {N,Z,C,V}
- EM_WB_EN, EM_MEM_R_EN, EM_MEM_W_EN  out  1 each  registered control
- EM_ALU_Res  out  32  registered ALU result / memory address
- EM_Val_Rm  out  32  registered store data (forwarded Rm)
- EM_Dest  out  4  registered destination

## Operation
- op1 = mux(Sel_src1; Val_Rn, MEM_fwd_val, WB_fwd_val).
- rm_fwd = mux(Sel_src2; Val_Rm, MEM_fwd_val, WB_fwd_val).
- op2 = I ? Imm32 : rm_fwd.
- The ALU uses carry-in cin = SR.C.
- EXE_CMD decode, result r:
  - 0001 MOV: r = op2
  - 1001 MVN: r = ~op2
  - 0010 ADD / LDR / STR: r = op1 + op2
  - 0011 ADC: r = op1 + op2 + cin
  - 0100 SUB / CMP: r = op1 - op2
  - 0101 SBC: r = op1 - op2 - ~cin
  - 0110 AND / TST: r = op1 & op2
  - 0111 ORR: r = op1 | op2
  - 1000 EOR: r = op1 ^ op2
  - any other code: r = 0 and flags unchanged
- Flags:
  - N = r[31]; Z = (r == 0).
  - Add forms: C = bit 32 of the 33-bit sum. V = (op1[31] == op2[31]) && (r[31] != op1[31]).
  - Subtract forms: C = NOT borrow, i.e. 1 when op1 ≥ op2 (+borrow) unsigned. V = (op1[31] != op2[31]) && (r[31] != op1[31]).
  - Logic, MOV and MVN: C and V keep their SR values.
- Br_addr = PC + (sign_extend(Signed_imm_24) << 2), computed mod 2^32.
- EM_Val_Rm always carries rm_fwd, even when I = 1.

## Timing
- On rst, at the clock edge, all EM_* outputs go to 0 and SR goes to 4'b0000. rst has priority over freeze.
- EXE/MEM register:
  - Loads every rising edge when freeze = 0.
  - Holds all fields when freeze = 1.
  - Latency is 1 cycle from ID/EXE inputs to EM_* outputs.
- Status register:
  - Loads the new NZCV at the edge when S = 1 and freeze = 0.
  - Otherwise holds.
  - The new value is visible on SR the cycle after the update.
  - A back-to-back ADC/SBC therefore uses the carry written by the previous instruction.
- Br_taken, Br_addr and the ALU path are combinational within the cycle, with no registered delay.
- Forwarded values are sampled in the same cycle as the selects.
- While freeze = 1, the ALU continues computing, but nothing is committed.
- No internal state beyond the EXE/MEM register and SR.

## Test plan
- Forwarding:
  - Stimulus: Val_Rn = 5, MEM_fwd_val = 7, WB_fwd_val = 9, EXE_CMD = ADD, I = 1, Imm32 = 1.
  - Sweep Sel_src1 over 0, 1, 2, 3.
  - Required EM_ALU_Res after 1 cycle: 6, 8, 10, 6.
- ADD overflow:
  - Stimulus: op1 = 0x7FFFFFFF, op2 = 1, S = 1.
  - Required: EM_ALU_Res = 0x80000000 and next-cycle SR = 1001.
- SUB, then SBC:
  - Stimulus: CMP 3 - 3 with S = 1. Next cycle: SBC 10 - 4 with S = 1.
  - Required: SR = 0110 after the CMP; SBC result = 6 (cin = 1); SR = 0010 after the SBC.
- Freeze:
  - Stimulus: load ADD 1 + 2, then assert freeze for 3 cycles while the inputs change to SUB with S = 1.
  - Required: EM_ALU_Res stays 3 and SR is unchanged throughout; the SUB result appears 1 cycle after freeze drops.
- Reset mid-operation:
  - Stimulus: assert rst together with freeze after nonzero EM_* and SR values.
  - Required: all EM_* = 0 and SR = 0 at that edge.
- Branch:
  - Stimulus: PC = 0x100, Signed_imm_24 = 0xFFFFFE, B = 1.
  - Required: Br_taken = 1 and Br_addr = 0xF8 in the same cycle.
